// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 4:1 mux scan controller.
package mux4_scan_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_scan_ctrl_dwell_timer.sv
// Dwell counter: while run is high, tick pulses once every DWELL cycles on the
// cycle whose closing edge is the sample edge. Idles at zero when run is low.
module dwell_timer #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("dwell_timer: DWELL must be in 1..255");
  end
  if ((DWELL - 1) >= (2 ** DWELL_W)) begin : g_bad_width
    $error("dwell_timer: DWELL_W too narrow for DWELL");
  end

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] dwell_cnt;

  assign tick = run && (dwell_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (!run || tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the selects, samples f per channel and
// hands each 4-bit frame downstream over valid/ready, flagging dropped frames.
//
// Handshake: a transfer happens on any edge where frame_valid & frame_ready;
// frame is held stable while frame_valid=1 and no transfer occurs, and
// frame_ready is ignored while frame_valid=0.
module mux4_scan_ctrl
  import mux4_scan_ctrl_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_f,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       overrun,
  input  logic       overrun_clr
);

  state_t            state, state_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [NUM_CH-2:0] shadow, shadow_n;
  logic [3:0]        frame_n;
  logic              valid_n;
  logic              overrun_n;
  logic              tick;
  logic              commit;
  logic              drop;

  dwell_timer #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (state == ST_SCAN),
    .tick (tick)
  );

  // ch is 0 whenever the FSM is idle, so selects read 00 there without muxing.
  assign {s1, s0} = ch;
  assign busy     = (state == ST_SCAN);

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    shadow_n  = shadow;
    frame_n   = frame;
    valid_n   = frame_valid;
    overrun_n = overrun;
    commit    = 1'b0;
    drop      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SCAN;
          ch_n    = '0;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          if (ch == CH_W'(NUM_CH - 1)) begin
            commit  = 1'b1;
            ch_n    = '0;
            state_n = cont ? ST_SCAN : ST_IDLE;
          end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
              if (ch == CH_W'(i)) shadow_n[i] = mux_f;
            end
            ch_n = ch + CH_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (frame_valid && frame_ready) valid_n = 1'b0;

    // The last channel goes straight into the frame; no shadow bit is needed.
    if (commit) begin
      if (!frame_valid || frame_ready) begin
        frame_n = {mux_f, shadow};
        valid_n = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (overrun_clr) overrun_n = 1'b0;
    if (drop)        overrun_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ch          <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      ch          <= ch_n;
      shadow      <= shadow_n;
      frame       <= frame_n;
      frame_valid <= valid_n;
      overrun     <= overrun_n;
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: one instance at DWELL=4, one at DWELL=1,
// each with a behavioural 4:1 mux closing the select/f loop.
module tb_mux4_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DWELL=4 instance
  logic       start4 = 0, cont4 = 0, ready4 = 0, clr4 = 0;
  logic [3:0] x4 = 4'b0000;
  logic       f4, s0_4, s1_4, busy4, valid4, ovr4;
  logic [3:0] frame4;
  assign f4 = x4[{s1_4, s0_4}];

  // DWELL=1 instance
  logic       start1 = 0, cont1 = 0, ready1 = 0, clr1 = 0;
  logic [3:0] x1 = 4'b0000;
  logic       f1, s0_1, s1_1, busy1, valid1, ovr1;
  logic [3:0] frame1;
  assign f1 = x1[{s1_1, s0_1}];

  int total = 0;
  int bad   = 0;

  mux4_scan_ctrl #(.DWELL(4), .DWELL_W(8)) u_dut4 (
    .clk (clk), .rst (rst), .start (start4), .cont (cont4), .mux_f (f4),
    .s0 (s0_4), .s1 (s1_4), .busy (busy4), .frame (frame4),
    .frame_valid (valid4), .frame_ready (ready4),
    .overrun (ovr4), .overrun_clr (clr4)
  );

  mux4_scan_ctrl #(.DWELL(1), .DWELL_W(8)) u_dut1 (
    .clk (clk), .rst (rst), .start (start1), .cont (cont1), .mux_f (f1),
    .s0 (s0_1), .s1 (s1_1), .busy (busy1), .frame (frame1),
    .frame_valid (valid1), .frame_ready (ready1),
    .overrun (ovr1), .overrun_clr (clr1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if ({s1_4, s0_4, busy4, frame4, valid4, ovr4} !== 9'b0) begin
      $display("FAIL reset_dut4 got=%b exp=%b", {s1_4, s0_4, busy4, frame4, valid4, ovr4}, 9'b0);
      bad++;
    end
    total++;
    if ({s1_1, s0_1, busy1, frame1, valid1, ovr1} !== 9'b0) begin
      $display("FAIL reset_dut1 got=%b exp=%b", {s1_1, s0_1, busy1, frame1, valid1, ovr1}, 9'b0);
      bad++;
    end
    rst = 1'b0;
    step(1);
  endtask

  // Single shot, DWELL=4, x=1010.
  task automatic test_single_shot();
    logic [1:0] exp_sel;
    x4 = 4'b1010; cont4 = 0; ready4 = 0;
    start4 = 1; step(1); start4 = 0;             // E0
    for (int c = 0; c < 4; c++) begin
      exp_sel = 2'(c);
      total++;
      if ({s1_4, s0_4} !== exp_sel || busy4 !== 1'b1) begin
        $display("FAIL single_sel ch%0d got=%b busy=%b exp=%b busy=1", c, {s1_4, s0_4}, busy4, exp_sel);
        bad++;
      end
      step(3);
      total++;
      if ({s1_4, s0_4} !== exp_sel || valid4 !== 1'b0) begin
        $display("FAIL single_hold ch%0d got=%b valid=%b exp=%b valid=0", c, {s1_4, s0_4}, valid4, exp_sel);
        bad++;
      end
      step(1);
    end
    // now at E0+16
    total++;
    if (frame4 !== 4'b1010 || valid4 !== 1'b1) begin
      $display("FAIL single_frame got=%b valid=%b exp=1010 valid=1", frame4, valid4);
      bad++;
    end
    total++;
    if (busy4 !== 1'b0 || {s1_4, s0_4} !== 2'b00 || ovr4 !== 1'b0) begin
      $display("FAIL single_idle got busy=%b sel=%b ovr=%b exp 0 00 0", busy4, {s1_4, s0_4}, ovr4);
      bad++;
    end
  endtask

  // Continuous with no consumer: second commit overruns, then clear behaviour.
  task automatic test_overrun();
    do_reset();
    x4 = 4'b0110; cont4 = 1; ready4 = 0; clr4 = 0;
    start4 = 1; step(1); start4 = 0;             // E0
    step(16);                                    // E0+16
    total++;
    if (frame4 !== 4'b0110 || valid4 !== 1'b1 || ovr4 !== 1'b0 || busy4 !== 1'b1) begin
      $display("FAIL ovr_first got=%b v=%b o=%b b=%b exp 0110 1 0 1", frame4, valid4, ovr4, busy4);
      bad++;
    end
    step(16);                                    // E0+32
    total++;
    if (frame4 !== 4'b0110 || valid4 !== 1'b1 || ovr4 !== 1'b1) begin
      $display("FAIL ovr_set got=%b v=%b o=%b exp 0110 1 1", frame4, valid4, ovr4);
      bad++;
    end
    clr4 = 1; step(1); clr4 = 0;                 // E0+33
    total++;
    if (ovr4 !== 1'b0) begin
      $display("FAIL ovr_clear got=%b exp=0", ovr4);
      bad++;
    end
    cont4 = 0;
    step(14);                                    // E0+47
    clr4 = 1; step(1);                           // E0+48: set and clear together
    total++;
    if (ovr4 !== 1'b1 || busy4 !== 1'b0 || frame4 !== 4'b0110) begin
      $display("FAIL ovr_set_wins got o=%b b=%b f=%b exp 1 0 0110", ovr4, busy4, frame4);
      bad++;
    end
    step(1); clr4 = 0;
    total++;
    if (ovr4 !== 1'b0) begin
      $display("FAIL ovr_clear_idle got=%b exp=0", ovr4);
      bad++;
    end
  endtask

  // Continuous with ready on the second commit edge: replacement, no overrun.
  task automatic test_back_to_back();
    do_reset();
    x4 = 4'b1111; cont4 = 1; ready4 = 0;
    start4 = 1; step(1); start4 = 0;             // E0
    step(16);                                    // E0+16
    total++;
    if (frame4 !== 4'b1111 || valid4 !== 1'b1) begin
      $display("FAIL b2b_first got=%b v=%b exp 1111 1", frame4, valid4);
      bad++;
    end
    x4 = 4'b0001;
    step(15);                                    // E0+31
    ready4 = 1; step(1); ready4 = 0;             // E0+32
    total++;
    if (frame4 !== 4'b0001 || valid4 !== 1'b1 || ovr4 !== 1'b0) begin
      $display("FAIL b2b_second got=%b v=%b o=%b exp 0001 1 0", frame4, valid4, ovr4);
      bad++;
    end
  endtask

  // Continues from test_back_to_back: reset lands on ch=1 of the third frame.
  task automatic test_reset_mid_scan();
    step(6);                                     // E0+38
    total++;
    if ({s1_4, s0_4} !== 2'b01 || busy4 !== 1'b1) begin
      $display("FAIL mid_pre got sel=%b b=%b exp 01 1", {s1_4, s0_4}, busy4);
      bad++;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({s1_4, s0_4, busy4, frame4, valid4, ovr4} !== 9'b0) begin
      $display("FAIL mid_async got=%b exp=%b", {s1_4, s0_4, busy4, frame4, valid4, ovr4}, 9'b0);
      bad++;
    end
    step(2);
    rst = 1'b0; cont4 = 0; x4 = 4'b1100;
    step(1);
    start4 = 1; step(1); start4 = 0;             // E0
    step(15);
    total++;
    if (valid4 !== 1'b0 || {s1_4, s0_4} !== 2'b11) begin
      $display("FAIL mid_restart_pre got v=%b sel=%b exp 0 11", valid4, {s1_4, s0_4});
      bad++;
    end
    step(1);                                     // E0+16
    total++;
    if (frame4 !== 4'b1100 || valid4 !== 1'b1 || busy4 !== 1'b0) begin
      $display("FAIL mid_restart got=%b v=%b b=%b exp 1100 1 0", frame4, valid4, busy4);
      bad++;
    end
  endtask

  // DWELL=1: one channel per cycle, start while busy ignored.
  task automatic test_dwell_one();
    x1 = 4'b1001; cont1 = 0; ready1 = 0;
    start1 = 1; step(1); start1 = 0;             // E0
    total++;
    if ({s1_1, s0_1} !== 2'b00 || busy1 !== 1'b1) begin
      $display("FAIL d1_e0 got sel=%b b=%b exp 00 1", {s1_1, s0_1}, busy1);
      bad++;
    end
    step(1);                                     // E0+1
    total++;
    if ({s1_1, s0_1} !== 2'b01) begin
      $display("FAIL d1_e1 got sel=%b exp 01", {s1_1, s0_1});
      bad++;
    end
    start1 = 1; step(1); start1 = 0;             // E0+2, start ignored
    total++;
    if ({s1_1, s0_1} !== 2'b10 || busy1 !== 1'b1) begin
      $display("FAIL d1_e2 got sel=%b b=%b exp 10 1", {s1_1, s0_1}, busy1);
      bad++;
    end
    step(1);                                     // E0+3
    total++;
    if ({s1_1, s0_1} !== 2'b11 || valid1 !== 1'b0) begin
      $display("FAIL d1_e3 got sel=%b v=%b exp 11 0", {s1_1, s0_1}, valid1);
      bad++;
    end
    step(1);                                     // E0+4
    total++;
    if (frame1 !== 4'b1001 || valid1 !== 1'b1 || busy1 !== 1'b0 || {s1_1, s0_1} !== 2'b00) begin
      $display("FAIL d1_frame got f=%b v=%b b=%b sel=%b exp 1001 1 0 00", frame1, valid1, busy1, {s1_1, s0_1});
      bad++;
    end
    step(1);
    total++;
    if (busy1 !== 1'b0) begin
      $display("FAIL d1_start_ignored got b=%b exp 0", busy1);
      bad++;
    end
  endtask

  // Frame held under backpressure, then a single-cycle transfer.
  task automatic test_hold_and_transfer();
    do_reset();
    x4 = 4'b0101; cont4 = 0; ready4 = 0;
    start4 = 1; step(1); start4 = 0;
    step(16);
    for (int i = 0; i < 10; i++) begin
      x4 = 4'(~i);
      total++;
      if (frame4 !== 4'b0101 || valid4 !== 1'b1) begin
        $display("FAIL hold cyc%0d got=%b v=%b exp 0101 1", i, frame4, valid4);
        bad++;
      end
      step(1);
    end
    ready4 = 1; step(1); ready4 = 0;
    total++;
    if (valid4 !== 1'b0 || ovr4 !== 1'b0) begin
      $display("FAIL xfer got v=%b o=%b exp 0 0", valid4, ovr4);
      bad++;
    end
    ready4 = 1; step(2); ready4 = 0;
    total++;
    if (valid4 !== 1'b0 || frame4 !== 4'b0101) begin
      $display("FAIL ready_while_empty got v=%b f=%b exp 0 0101", valid4, frame4);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_overrun();
    test_back_to_back();
    test_reset_mid_scan();
    test_dwell_one();
    test_hold_and_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
